// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bundle for sync_fifo_param: write port, read port and status.
interface sync_fifo_param_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic             flush;
    logic             wr_en;
    logic [WIDTH-1:0] din;
    logic             full;
    logic             almost_full;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             empty;
    logic             almost_empty;
    logic [AW:0]      count;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, wr_en, din, rd_en,
        input  full, almost_full, dout, dout_valid, empty, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, din, rd_en,
        output full, almost_full, dout, dout_valid, empty, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// sticky error flags, synchronous flush and a registered read port.
module sync_fifo_param #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    sync_fifo_param_if.slave    bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] dout_q;
    logic             dout_valid_q;
    logic             overflow_q;
    logic             underflow_q;

    logic full_c;
    logic empty_c;
    logic rd_ok_c;
    logic wr_ok_c;

    // The count register is CW bits, so all DEPTH slots are usable.
    assign full_c  = (count_q == CW'(DEPTH));
    assign empty_c = (count_q == '0);
    assign rd_ok_c = bus.rd_en & ~empty_c;
    assign wr_ok_c = bus.wr_en & (~full_c | rd_ok_c);

    assign bus.full         = full_c;
    assign bus.empty        = empty_c;
    assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
    assign bus.count        = count_q;
    assign bus.dout         = dout_q;
    assign bus.dout_valid   = dout_valid_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_ok_c && !bus.flush) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else if (bus.flush) begin
            // Flush wins over same-cycle requests; dout keeps its last value.
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count_q      <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            if (wr_ok_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok_c) begin
                dout_q <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            dout_valid_q <= rd_ok_c;

            case ({wr_ok_c, rd_ok_c})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase

            if (bus.wr_en && !wr_ok_c) begin
                overflow_q <= 1'b1;
            end
            if (bus.rd_en && empty_c) begin
                underflow_q <= 1'b1;
            end
        end
    end
endmodule
